// File: rtl/rr_mux_reg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_reg
//  Purpose  : N-way registered mux; round-robin or fixed channel select,
//             valid/ready on every input and on the one-entry output register.
//  Revision : 1.0  initial release
// ============================================================================

module rr_mux_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [CHANNELS*WIDTH-1:0]                          data_in,
    input  logic [CHANNELS-1:0]                                valid_in,
    output logic [CHANNELS-1:0]                                ready_out,
    input  logic                                               mode_in,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] select_in,
    output logic [WIDTH-1:0]                                   data_out,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] channel_out,
    output logic                                               valid_out,
    input  logic                                               ready_in
);

    localparam int c_SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_SLOTS = 2 ** c_SEL_W;
    localparam logic [c_SEL_W-1:0] c_LAST = c_SEL_W'(CHANNELS - 1);

    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [c_SEL_W-1:0] r_chan;
    logic [c_SEL_W-1:0] r_ptr;

    logic [c_SLOTS-1:0] w_valid_pad;
    logic [WIDTH-1:0]   w_data_pad [c_SLOTS];
    logic               w_rr_found;
    logic [c_SEL_W-1:0] w_rr_idx;
    logic               w_fx_found;
    logic [c_SEL_W-1:0] w_grant;
    logic               w_grant_vld;
    logic               w_accept;
    logic               w_fire;
    logic [c_SEL_W-1:0] w_next_ptr;

    // Pad the channel set up to a power of two so any select value indexes
    // safely; padded slots never request, which handles out-of-range selects.
    generate
        for (genvar i = 0; i < c_SLOTS; i++) begin : g_slot
            if (i < CHANNELS) begin : g_live
                assign w_valid_pad[i] = valid_in[i];
                assign w_data_pad[i]  = data_in[i*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_valid_pad[i] = 1'b0;
                assign w_data_pad[i]  = '0;
            end
        end
    endgenerate

    // Scan starting at the pointer; offset arithmetic wraps at CHANNELS, not
    // at the power-of-two slot count.
    always_comb begin
        int                 w_scan;
        logic [c_SEL_W-1:0] w_cand;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_scan     = 0;
        w_cand     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_scan = int'(r_ptr) + k;
            if (w_scan >= CHANNELS) begin
                w_scan = w_scan - CHANNELS;
            end
            w_cand = c_SEL_W'(w_scan);
            if (!w_rr_found && w_valid_pad[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    assign w_fx_found  = w_valid_pad[select_in];
    assign w_grant     = mode_in ? select_in  : w_rr_idx;
    assign w_grant_vld = mode_in ? w_fx_found : w_rr_found;
    assign w_accept    = !r_valid || ready_in;
    assign w_fire      = rst_n && w_accept && w_grant_vld;
    assign w_next_ptr  = (w_grant == c_LAST) ? '0 : w_grant + c_SEL_W'(1);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ready
            assign ready_out[i] = w_fire && (w_grant == c_SEL_W'(i));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_chan  <= '0;
            r_ptr   <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_data  <= w_data_pad[w_grant];
            r_chan  <= w_grant;
            if (!mode_in) begin
                r_ptr <= w_next_ptr;
            end
        end else if (ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign data_out    = r_data;
    assign channel_out = r_chan;
    assign valid_out   = r_valid;

endmodule

`default_nettype wire

// File: doc/rr_mux_reg.md
# rr_mux_reg

Parametrised N-way, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes. It is the next generation of the datapath 2:1 select mux. It either arbitrates round-robin among the requesting channels or forwards one externally selected channel. The result lands in a one-entry output register with its own valid/ready handshake. It sits between multi-source producers in the datapath (writeback sources, forwarding paths, memory return ports) and a single consumer that may stall.

## Interface
- WIDTH, 32, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2); SEL_W = max(1, clog2(CHANNELS)) is derived, not a parameter
- clk  input  1  rising-edge clock; single clock domain
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- data_in  input  CHANNELS*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH]
- valid_in  input  CHANNELS  per-channel request
- ready_out  output  CHANNELS  per-channel accept; at most one bit high
- mode_in  input  1  0 = round-robin arbitration, 1 = fixed select
- select_in  input  SEL_W  channel index used when mode_in=1
- data_out  output  WIDTH  registered selected data
- channel_out  output  SEL_W  index of the channel that produced data_out
- valid_out  output  1  data_out/channel_out hold a valid entry
- ready_in  input  1  consumer accepts the output entry

## Operation
- Output register: one entry (valid_out, data_out, channel_out). It is emptied by an output transfer (valid_out && ready_in).
- accept_en = !valid_out || ready_in. The block can load a new entry in the same cycle the old one drains, so throughput is 1 per cycle.
- Grant selection (combinational, from current-cycle inputs):
  - mode_in=0: scan channels ptr, ptr+1, …, wrapping modulo CHANNELS. The first channel with valid_in set wins.
  - mode_in=1: grant = select_in if select_in < CHANNELS and valid_in[select_in]=1. Otherwise there is no grant.
- ready_out[i] = accept_en && grant valid && grant==i. No other channel is ever readied.
- Input transfer on channel i when valid_in[i] && ready_out[i]. On the next edge: data_out ← channel i data, channel_out ← i, valid_out ← 1.
- No input transfer but an output transfer: valid_out ← 0. data_out and channel_out hold their last values.
- Round-robin pointer ptr (SEL_W bits): on an input transfer with mode_in=0, ptr ← (i+1) mod CHANNELS. Wrap is explicit: from CHANNELS-1 to 0, including non-power-of-2 CHANNELS.
- ptr is unchanged in mode_in=1 and on cycles with no transfer.
- Mode switches take effect in the same cycle. No drain is required and any pending output entry is unaffected.
- ready_out depends combinationally on valid_in, mode_in, select_in, valid_out and ready_in. Producers must not make valid_in depend on ready_out.
- Once valid_in is high, a producer holds it and its data stable until the transfer.

## Timing
- Reset (rst_n=0 at an edge): valid_out=0, data_out=0, channel_out=0, ptr=0. ready_out is all-zero during any cycle in which rst_n=0.
- Reset mid-operation: any held output entry is discarded and no transfer is reported in that cycle.
- Latency: input transfer at edge N → valid_out=1 with that data after edge N. The consumer sees it in cycle N+1.
- Stall: while valid_out=1 and ready_in=0, data_out, channel_out and valid_out stay constant and ready_out is all-zero.
- Simultaneous drain and fill: the new entry replaces the old one at the same edge with no bubble.
- No valid_in set, or the fixed select is out of range (select_in ≥ CHANNELS): ready_out=0 and the entry drains normally.
- Fairness: in mode 0 with every channel continuously valid and ready_in=1, the grant order is ptr, ptr+1, … with each channel served once per CHANNELS transfers.

## Test plan
- Reset: assert rst_n=0 for 2 cycles with all valid_in=1. Required: valid_out=0, data_out=0, channel_out=0, ready_out=0. First grant after release is channel 0.
- Round-robin, CHANNELS=4, WIDTH=32: all valid_in=1, data_in[i]=32'hA000_000i, ready_in=1. Required: channel_out sequence 0,1,2,3,0 on consecutive cycles with matching data and no bubbles.
- Backpressure: channel 1 is granted, then ready_in=0 for 3 cycles. Required: data_out=32'hA000_0001 is held, ready_out=0, and channel 2 is taken the cycle after ready_in returns to 1.
- Fixed mode: mode_in=1, select_in=2, all valid. Required: only ready_out[2] is high, channel_out=2 repeatedly, and ptr is unchanged. Returning to mode_in=0 resumes from the prior ptr.
- Out-of-range select, CHANNELS=3, SEL_W=2: mode_in=1, select_in=3, all valid. Required: ready_out=3'b000 and valid_out falls to 0 after the pending entry drains.
- Reset mid-operation: valid_out=1 with ready_in=0, then rst_n=0 for one edge. Required: valid_out=0, data_out=0, channel_out=0 next cycle. The next mode-0 grant is channel 0 (ptr=0).
